fifo_read_stream: RTL and testbench

FIFO_READ_STREAM -- requirements
Module: fifo_read_stream

---
 rtl/fifo_read_stream_if.sv | 29 ++
 rtl/fifo_read_stream.sv | 90 +++++++++
 tb/tb_fifo_read_stream.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_read_stream_if.sv
// Read-side FIFO handshake plus downstream valid/ready stream, bundled for fifo_read_stream.
interface fifo_read_stream_if #(
    parameter int unsigned WIDTH = 32
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_rd_en;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  m_ready,
        output fifo_rd_en,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        output m_ready,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/fifo_read_stream.sv
// Turns a one-cycle-latency FIFO read port into a valid/ready stream via a 2-entry buffer,
// with synchronous flush and a wrapping count of delivered words.
module fifo_read_stream #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rstn,
    fifo_read_stream_if.master bus,
    input  logic               flush,
    output logic [CNT_W-1:0]   rd_count
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    occ_e             state;
    occ_e             state_next;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic             infl;
    logic             drop;
    logic             run;
    logic             pop;
    logic             capture;
    logic             rd_en;
    logic             wr_head;
    logic [1:0]       occ;
    logic [1:0]       occ_next;
    logic [2:0]       pending;

    always_comb begin
        occ      = state;
        pop      = (state != EMPTY) && bus.m_ready;
        capture  = infl && !drop;
        // Words committed once this cycle resolves; rd_en only if a slot is still free.
        pending  = {1'b0, occ} + {2'b00, infl} - {2'b00, pop};
        rd_en    = run && !bus.fifo_empty && !flush && (pending < 3'd2);
        occ_next = occ + {1'b0, capture} - {1'b0, pop};
        wr_head  = (occ == 2'd0) || ((occ == 2'd1) && pop);
        state_next = state;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (occ_next)
                2'd0:    state_next = EMPTY;
                2'd1:    state_next = ONE;
                default: state_next = TWO;
            endcase
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = (state != EMPTY);
    assign bus.m_data     = head;

    // run gates rd_en until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= EMPTY;
            infl     <= 1'b0;
            drop     <= 1'b0;
            run      <= 1'b0;
            rd_count <= '0;
        end else begin
            state <= state_next;
            infl  <= rd_en;
            drop  <= flush;
            run   <= 1'b1;
            if (pop) begin
                rd_count <= rd_count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            head <= tail;
        end
        if (capture && !flush) begin
            if (wr_head) begin
                head <= bus.fifo_data;
            end else begin
                tail <= bus.fifo_data;
            end
        end
    end
endmodule

// File: tb/tb_fifo_read_stream.sv
// Scoreboard bench for fifo_read_stream: behavioural FIFO model feeds an expected-word queue,
// an independent monitor pops and compares on every output handshake.
module tb_fifo_read_stream;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             flush = 1'b0;
    logic [CNT_W-1:0] rd_count;

    fifo_read_stream_if #(.WIDTH(WIDTH)) bus ();

    fifo_read_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus.master),
        .flush    (flush),
        .rd_count (rd_count)
    );

    always #10 clk = ~clk;

    logic [WIDTH-1:0] fifo_q[$];
    logic [WIDTH-1:0] exp_q[$];
    int               pop_cyc_q[$];
    logic [CNT_W-1:0] model_cnt = '0;
    int               vectors = 0;
    int               miscompares = 0;
    int               cyc = 0;
    int               rden_cycles = 0;
    logic             empty_force = 1'b0;
    logic             pend = 1'b0;
    logic [WIDTH-1:0] pend_word = '0;
    logic             stall_prev = 1'b0;
    logic [WIDTH-1:0] stall_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every handshake against the expected queue and the word count.
    always @(negedge clk) begin
        #2;
        if (!rstn) begin
            exp_q.delete();
            model_cnt  = '0;
            stall_prev = 1'b0;
        end else begin
            chk("rd_count", 64'(rd_count), 64'(model_cnt));
            chk("rd_en_while_empty", 64'(bus.fifo_rd_en && bus.fifo_empty), 64'd0);
            if (stall_prev) begin
                chk("stall_valid", 64'(bus.m_valid), 64'd1);
                chk("stall_data", 64'(bus.m_data), 64'(stall_data));
            end
            if (bus.m_valid && bus.m_ready) begin
                pop_cyc_q.push_back(cyc);
                model_cnt = model_cnt + 1'b1;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_word: got 0x%0h expected no word (cycle %0d)", bus.m_data, cyc);
                end else begin
                    chk("m_data", 64'(bus.m_data), 64'(exp_q.pop_front()));
                end
            end
            stall_prev = bus.m_valid && !bus.m_ready && !flush;
            stall_data = bus.m_data;
            if (flush) exp_q.delete();
        end
    end

    // One clock cycle of stimulus including the FIFO model's read port behaviour.
    task automatic step(input logic rdy, input logic fl);
        @(negedge clk);
        bus.m_ready    = rdy;
        flush          = fl;
        bus.fifo_empty = (fifo_q.size() == 0) || empty_force;
        cyc++;
        #3;
        pend = 1'b0;
        if (rstn && bus.fifo_rd_en && !bus.fifo_empty && fifo_q.size() > 0) begin
            pend_word = fifo_q.pop_front();
            exp_q.push_back(pend_word);
            pend = 1'b1;
            rden_cycles++;
        end
        @(posedge clk);
        #1;
        if (pend) bus.fifo_data = pend_word;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.m_ready = 1'b0;
        flush       = 1'b0;
        #4;
        rstn = 1'b0;
        #1;
        chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
        chk("rst_rd_count", 64'(rd_count), 64'd0);
        chk("rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
        repeat (2) @(negedge clk);
        bus.fifo_empty = (fifo_q.size() == 0) || empty_force;
        #1;
        rstn = 1'b1;
        #1;
        chk("rd_en_at_release", 64'(bus.fifo_rd_en), 64'd0);
    endtask

    initial begin
        int idx0;
        int c0;
        int r0;
        logic [WIDTH-1:0] w;
        bus.m_ready    = 1'b0;
        bus.fifo_empty = 1'b1;
        repeat (2) @(negedge clk);
        #1 rstn = 1'b1;
        do_reset();

        // Three preloaded words, downstream always ready.
        fifo_q = '{32'h11, 32'h22, 32'h33};
        idx0 = pop_cyc_q.size();
        r0 = rden_cycles;
        c0 = cyc + 1;
        repeat (8) step(1'b1, 1'b0);
        chk("t1_rd_en_cycles", 64'(rden_cycles - r0), 64'd3);
        chk("t1_pops", 64'(pop_cyc_q.size() - idx0), 64'd3);
        chk("t1_rd_count", 64'(rd_count), 64'd3);
        if (pop_cyc_q.size() - idx0 == 3) begin
            chk("t1_latency", 64'(pop_cyc_q[idx0] - c0), 64'd2);
            chk("t1_back_to_back", 64'(pop_cyc_q[idx0+2] - pop_cyc_q[idx0]), 64'd2);
        end

        // Five words with downstream stalled, then released.
        for (int i = 0; i < 5; i++) fifo_q.push_back($urandom);
        r0 = rden_cycles;
        idx0 = pop_cyc_q.size();
        repeat (10) step(1'b0, 1'b0);
        chk("t2_rd_en_stalled", 64'(rden_cycles - r0), 64'd2);
        chk("t2_valid_stalled", 64'(bus.m_valid), 64'd1);
        repeat (10) step(1'b1, 1'b0);
        chk("t2_pops", 64'(pop_cyc_q.size() - idx0), 64'd5);
        chk("t2_rd_count", 64'(rd_count), 64'd8);

        // Flush with one word buffered and one in flight.
        fifo_q = '{32'hA0, 32'hB0, 32'hC0, 32'hD0};
        idx0 = pop_cyc_q.size();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("t3_valid_after_flush", 64'(bus.m_valid), 64'd0);
        repeat (8) step(1'b1, 1'b0);
        chk("t3_pops_after_flush", 64'(pop_cyc_q.size() - idx0), 64'd2);
        chk("t3_rd_count", 64'(rd_count), 64'd10);

        // Reset with the buffer full; only words never read may appear afterwards.
        fifo_q = '{32'h5A, 32'h6B, 32'h7C, 32'h8D};
        repeat (5) step(1'b0, 1'b0);
        chk("t4_valid_full", 64'(bus.m_valid), 64'd1);
        do_reset();
        idx0 = pop_cyc_q.size();
        repeat (8) step(1'b1, 1'b0);
        chk("t4_pops_after_reset", 64'(pop_cyc_q.size() - idx0), 64'd2);

        // Empty flag toggling every cycle, random ready and occasional flush.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) != 0 && fifo_q.size() < 8) fifo_q.push_back($urandom);
            empty_force = i[0];
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
        end
        empty_force = 1'b0;
        repeat (30) step(1'b1, 1'b0);
        chk("t5_fifo_drained", 64'(fifo_q.size()), 64'd0);
        chk("t5_no_loss", 64'(exp_q.size()), 64'd0);

        // Counter wrap at full throughput.
        do_reset();
        for (int i = 0; i < 65535; i++) begin
            w = WIDTH'(i);
            fifo_q.push_back(w ^ 32'h5555_0000);
        end
        repeat (65538) step(1'b1, 1'b0);
        chk("t6_rd_count_max", 64'(rd_count), 64'hFFFF);
        fifo_q.push_back(32'hCAFE_F00D);
        repeat (5) step(1'b1, 1'b0);
        chk("t6_rd_count_wrap", 64'(rd_count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
